// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: AXI read-address/read-data channels toward memory
// and the instruction valid/ready stream toward the decoder.
interface fetch_unit_if #(
   parameter int unsigned ID_WIDTH   = 13,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64
);
   logic [ID_WIDTH-1:0]   m_axi_arid;
   logic [ADDR_WIDTH-1:0] m_axi_araddr;
   logic [7:0]            m_axi_arlen;
   logic [2:0]            m_axi_arsize;
   logic [1:0]            m_axi_arburst;
   logic                  m_axi_arlock;
   logic [3:0]            m_axi_arcache;
   logic [2:0]            m_axi_arprot;
   logic                  m_axi_arvalid;
   logic                  m_axi_arready;
   logic [DATA_WIDTH-1:0] m_axi_rdata;
   logic [1:0]            m_axi_rresp;
   logic                  m_axi_rlast;
   logic                  m_axi_rvalid;
   logic                  m_axi_rready;
   logic                  inst_valid;
   logic                  inst_ready;
   logic [31:0]           inst;
   logic [63:0]           inst_pc;
   logic                  inst_err;

   modport master (
      output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
             inst_valid, inst, inst_pc, inst_err,
      input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
             inst_ready
   );

   modport slave (
      input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
             inst_valid, inst, inst_pc, inst_err,
      output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
             inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one 8-beat AXI burst per 64-byte line, streamed as 32-bit words.
// Optional FETCH_PERF_EN adds saturating perf_lines / perf_stalls counters.
module fetch_unit #(
   parameter int unsigned ID_WIDTH   = 13,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned AXI_ID     = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [63:0]         entry,
   input  logic                redirect_valid,
   input  logic [63:0]         redirect_pc,
   fetch_unit_if.master        bus,
   output logic                busy
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]         perf_lines,
   output logic [31:0]         perf_stalls
`endif
);

   typedef enum logic [1:0] {REQ, RECV, SERVE, DRAIN} state_e;

   state_e                state_q;
   logic [63:0]           fetch_pc_q, fetch_pc_d;
   logic [63:0]           redir_pc, entry_pc;
   logic [2:0]            beat_cnt_q;
   logic                  line_err_q, pend_q;
   logic                  arvalid_q, rready_q, inst_valid_q;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0] line_q [8];
   logic [DATA_WIDTH-1:0] slot_beat;
   logic [3:0]            slot;
   logic                  inst_fire, beat_fire, last_fire;

   assign redir_pc  = redirect_pc & ~64'h3;
   assign entry_pc  = entry & ~64'h3;
   assign inst_fire = inst_valid_q & bus.inst_ready;
   assign beat_fire = rready_q & bus.m_axi_rvalid;
   assign last_fire = beat_fire & bus.m_axi_rlast;
   assign slot      = fetch_pc_q[5:2];

   // A redirect always owns the next PC, even when it coincides with a handshake.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = redir_pc;
      end else if (inst_fire) begin
         fetch_pc_d = fetch_pc_q + 64'd4;
      end
   end

   assign araddr_d = ADDR_WIDTH'({fetch_pc_d[63:6], 6'b0});

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= REQ;
         fetch_pc_q   <= entry_pc;
         beat_cnt_q   <= '0;
         line_err_q   <= 1'b0;
         pend_q       <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         inst_valid_q <= 1'b0;
         araddr_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         unique case (state_q)
            REQ: begin
               // arvalid is low in REQ only on the first cycle out of reset.
               if (!arvalid_q) begin
                  arvalid_q <= 1'b1;
                  araddr_q  <= araddr_d;
               end else begin
                  if (redirect_valid) pend_q <= 1'b1;
                  if (bus.m_axi_arready) begin
                     arvalid_q <= 1'b0;
                     rready_q  <= 1'b1;
                     state_q   <= (pend_q || redirect_valid) ? DRAIN : RECV;
                  end
               end
            end
            RECV: begin
               if (beat_fire) begin
                  line_q[beat_cnt_q] <= bus.m_axi_rdata;
                  beat_cnt_q         <= beat_cnt_q + 3'd1;
                  if (bus.m_axi_rresp != 2'b00) line_err_q <= 1'b1;
               end
               if (redirect_valid) begin
                  line_err_q <= 1'b0;
                  beat_cnt_q <= '0;
                  if (last_fire) begin
                     state_q   <= REQ;
                     rready_q  <= 1'b0;
                     arvalid_q <= 1'b1;
                     araddr_q  <= araddr_d;
                  end else begin
                     state_q <= DRAIN;
                  end
               end else if (last_fire) begin
                  state_q      <= SERVE;
                  rready_q     <= 1'b0;
                  inst_valid_q <= 1'b1;
                  beat_cnt_q   <= '0;
               end
            end
            SERVE: begin
               if (redirect_valid || (inst_fire && slot == 4'hF)) begin
                  state_q      <= REQ;
                  inst_valid_q <= 1'b0;
                  line_err_q   <= 1'b0;
                  arvalid_q    <= 1'b1;
                  araddr_q     <= araddr_d;
               end
            end
            DRAIN: begin
               if (last_fire) begin
                  state_q   <= REQ;
                  pend_q    <= 1'b0;
                  rready_q  <= 1'b0;
                  arvalid_q <= 1'b1;
                  araddr_q  <= araddr_d;
               end
            end
            default: state_q <= REQ;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_lines_q, perf_stalls_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_lines_q  <= '0;
         perf_stalls_q <= '0;
      end else begin
         if (state_q == RECV && last_fire && perf_lines_q != '1)
            perf_lines_q <= perf_lines_q + 32'd1;
         if (inst_valid_q && !bus.inst_ready && perf_stalls_q != '1)
            perf_stalls_q <= perf_stalls_q + 32'd1;
      end
   end

   assign perf_lines  = perf_lines_q;
   assign perf_stalls = perf_stalls_q;
`endif

   assign slot_beat = line_q[slot[3:1]];

   assign bus.m_axi_arid    = ID_WIDTH'(AXI_ID);
   assign bus.m_axi_araddr  = araddr_q;
   assign bus.m_axi_arlen   = 8'h7;
   assign bus.m_axi_arsize  = 3'h3;
   assign bus.m_axi_arburst = 2'h2;
   assign bus.m_axi_arlock  = 1'b0;
   assign bus.m_axi_arcache = 4'h0;
   assign bus.m_axi_arprot  = 3'h6;
   assign bus.m_axi_arvalid = arvalid_q;
   assign bus.m_axi_rready  = rready_q;
   assign bus.inst_valid    = inst_valid_q;
   assign bus.inst          = slot[0] ? slot_beat[63:32] : slot_beat[31:0];
   assign bus.inst_pc       = fetch_pc_q;
   assign bus.inst_err      = line_err_q;
   assign busy              = (state_q != SERVE);

endmodule
